mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_pkg.sv | 35 +++
 rtl/load_ext.sv | 32 +++
 rtl/mem_access.sv | 138 +++++++++++++
 tb/tb_mem_access.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage: width codes, FSM states,
// and the legality/alignment rules used when an access is accepted.
package mem_pkg;

    localparam logic [2:0] MEM_OP_B  = 3'b000;
    localparam logic [2:0] MEM_OP_H  = 3'b001;
    localparam logic [2:0] MEM_OP_W  = 3'b010;
    localparam logic [2:0] MEM_OP_BU = 3'b100;
    localparam logic [2:0] MEM_OP_HU = 3'b101;

    localparam int ACK_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            MEM_OP_B, MEM_OP_H, MEM_OP_W, MEM_OP_BU, MEM_OP_HU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Illegal codes report as aligned; legality is checked separately.
    function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            MEM_OP_H, MEM_OP_HU: return ~lo[0];
            MEM_OP_W:            return (lo == 2'b00);
            default:             return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_ext.sv
// Selects the addressed byte/half lane of a bus read word and sign- or
// zero-extends it to 32 bits according to the load width code.
module load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  op,
    output logic [31:0] data
);

    logic [31:0]        lane;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] ext_s;

    always_comb begin
        lane   = rdata >> {addr, 3'b000};
        byte_s = lane[7:0];
        half_s = lane[15:0];
        ext_s  = $signed(rdata);
        case (op)
            MEM_OP_B:  ext_s = byte_s;
            MEM_OP_H:  ext_s = half_s;
            MEM_OP_BU: ext_s = $signed({24'd0, lane[7:0]});
            MEM_OP_HU: ext_s = $signed({16'd0, lane[15:0]});
            default:   ext_s = $signed(rdata);
        endcase
        data = ext_s;
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: turns one execute-stage load/store into a single
// data-bus transaction, stalling upstream until it completes or times out.
module mem_access
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ex_valid_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] alu_C_i,
    input  logic [31:0] rf_rd2_i,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

    mem_state_e  state;
    logic [7:0]  wait_cnt;
    logic [2:0]  op_p0;
    logic [1:0]  lo_p0;
    logic        we_p0;
    logic        access_ok;
    logic        accept;
    logic        timeout;
    logic [31:0] load_word;

    function automatic logic [3:0] calc_be(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            MEM_OP_B, MEM_OP_BU: return 4'b0001 << lo;
            MEM_OP_H, MEM_OP_HU: return 4'b0011 << lo;
            default:             return 4'b1111;
        endcase
    endfunction

    // Replicating the narrow datum means the bus never has to shift store data.
    function automatic logic [31:0] calc_wdata(input logic [2:0] op, input logic [31:0] d);
        case (op)
            MEM_OP_B, MEM_OP_BU: return {4{d[7:0]}};
            MEM_OP_H, MEM_OP_HU: return {2{d[15:0]}};
            default:             return d;
        endcase
    endfunction

    assign access_ok = op_legal(mem_op_i) && op_aligned(mem_op_i, alu_C_i[1:0]);
    assign accept    = (state == ST_IDLE) && ex_valid_i && access_ok;
    assign timeout   = (wait_cnt == TIMEOUT_CNT);

    // Gated by reset so upstream is released the moment reset asserts.
    assign stall_o   = rst_n_i && (accept || (state == ST_BUS));

    load_ext u_load_ext (
        .rdata (bus_rdata_i),
        .addr  (lo_p0),
        .op    (op_p0),
        .data  (load_word)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            wait_cnt    <= 8'd0;
            op_p0       <= 3'd0;
            lo_p0       <= 2'd0;
            we_p0       <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'd0;
            bus_be_o    <= 4'd0;
            bus_wdata_o <= 32'd0;
            wb_valid_o  <= 1'b0;
            wb_data_o   <= 32'd0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ex_valid_i) begin
                        if (access_ok) begin
                            state       <= ST_BUS;
                            wait_cnt    <= 8'd0;
                            op_p0       <= mem_op_i;
                            lo_p0       <= alu_C_i[1:0];
                            we_p0       <= mem_we_i;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= mem_we_i;
                            bus_addr_o  <= {alu_C_i[31:2], 2'b00};
                            bus_be_o    <= calc_be(mem_op_i, alu_C_i[1:0]);
                            bus_wdata_o <= calc_wdata(mem_op_i, rf_rd2_i);
                        end else begin
                            misalign_o <= 1'b1;
                        end
                    end
                end
                ST_BUS: begin
                    // Ack is tested first so a same-cycle ack beats the timeout.
                    if (bus_ack_i) begin
                        state     <= ST_DONE;
                        bus_req_o <= 1'b0;
                        if (!we_p0) begin
                            wb_valid_o <= 1'b1;
                            wb_data_o  <= load_word;
                        end
                    end else if (timeout) begin
                        state     <= ST_IDLE;
                        bus_req_o <= 1'b0;
                        bus_err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a byte-lane level
// reference model of loads, stores, alignment, timeout and reset behaviour.
module tb_mem_access;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        ex_valid_i;
    logic        mem_we_i;
    logic [2:0]  mem_op_i;
    logic [31:0] alu_C_i;
    logic [31:0] rf_rd2_i;
    logic        stall_o;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_wb;

    mem_access #(.ACK_TIMEOUT(TO)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .ex_valid_i  (ex_valid_i),
        .mem_we_i    (mem_we_i),
        .mem_op_i    (mem_op_i),
        .alu_C_i     (alu_C_i),
        .rf_rd2_i    (rf_rd2_i),
        .stall_o     (stall_o),
        .wb_valid_o  (wb_valid_o),
        .wb_data_o   (wb_data_o),
        .misalign_o  (misalign_o),
        .bus_err_o   (bus_err_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: access size in bytes, 0 for an illegal code.
    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit op_signed(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] op, input logic [31:0] addr);
        int s = op_size(op);
        int off = int'(addr % 4);
        if (s == 4) return 4'hF;
        return 4'(((1 << s) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] d);
        logic [31:0] r;
        int s = op_size(op);
        for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        longint v;
        int s = op_size(op);
        int off = int'(addr % 4);
        v = (longint'(rdata) >> (8 * off)) & ((longint'(1) << (8 * s)) - 1);
        if (op_signed(op) && v >= (longint'(1) << (8 * s - 1))) v = v - (longint'(1) << (8 * s));
        return v[31:0];
    endfunction

    // One access from the accept cycle through to the first idle cycle after it.
    // ack_lat: BUS cycle index (0 = first) at which ack is raised; > TO means never.
    task automatic access(input logic we, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input int ack_lat, input logic [31:0] rdata,
                          output logic [31:0] got_wb, output int bus_cycles);
        int  s;
        bit  legal;
        bit  acked;
        s          = op_size(op);
        legal      = (s != 0) && (addr % s == 0);
        acked      = 0;
        bus_cycles = 0;
        got_wb     = 'x;
        ex_valid_i = 1'b1;
        mem_we_i   = we;
        mem_op_i   = op;
        alu_C_i    = addr;
        rf_rd2_i   = data;
        #1;
        check("stall_accept", stall_o, legal);
        @(posedge clk_i); #1;
        if (!legal) begin
            ex_valid_i = 1'b0;
            #1;
            check("misalign_pulse", misalign_o, 1'b1);
            check("misalign_noreq", bus_req_o, 1'b0);
            check("misalign_stall", stall_o, 1'b0);
            @(posedge clk_i); #1;
            check("misalign_end", misalign_o, 1'b0);
            check("misalign_noreq2", bus_req_o, 1'b0);
            return;
        end
        for (int k = 0; k <= TO; k++) begin
            ex_valid_i = 1'($urandom_range(0, 1));
            mem_op_i   = 3'($urandom);
            alu_C_i    = $urandom;
            mem_we_i   = 1'($urandom);
            bus_ack_i  = (k == ack_lat);
            bus_rdata_i = (k == ack_lat) ? rdata : $urandom;
            #1;
            bus_cycles++;
            check("bus_req", bus_req_o, 1'b1);
            check("bus_we", bus_we_o, we);
            check("bus_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
            check("bus_be", bus_be_o, model_be(op, addr));
            check("bus_wdata", bus_wdata_o, model_wdata(op, data));
            check("bus_stall", stall_o, 1'b1);
            check("bus_nowb", wb_valid_o, 1'b0);
            @(posedge clk_i); #1;
            if (bus_ack_i) acked = 1;
            bus_ack_i = 1'b0;
            if (acked) break;
        end
        if (acked) begin
            ex_valid_i = 1'($urandom_range(0, 1));
            mem_op_i   = 3'b010;
            alu_C_i    = 32'h40;
            #1;
            check("done_wbv", wb_valid_o, !we);
            if (!we) last_wb = model_load(op, addr, rdata);
            check("done_wbdata", wb_data_o, last_wb);
            check("done_stall", stall_o, 1'b0);
            check("done_noreq", bus_req_o, 1'b0);
            check("done_noerr", bus_err_o, 1'b0);
            got_wb = wb_data_o;
            @(posedge clk_i); #1;
            ex_valid_i = 1'b0;
            #1;
            check("post_wbv", wb_valid_o, 1'b0);
            check("post_hold", wb_data_o, last_wb);
            check("post_ignored", bus_req_o, 1'b0);
            check("post_nomis", misalign_o, 1'b0);
        end else begin
            ex_valid_i = 1'b0;
            #1;
            check("to_err", bus_err_o, 1'b1);
            check("to_noreq", bus_req_o, 1'b0);
            check("to_nowb", wb_valid_o, 1'b0);
            check("to_stall", stall_o, 1'b0);
            @(posedge clk_i); #1;
            check("to_err_end", bus_err_o, 1'b0);
            check("to_hold", wb_data_o, last_wb);
        end
    endtask

    initial begin
        logic [31:0] got;
        int          nb;
        logic [2:0]  op;
        logic [31:0] addr;
        int          lat;

        rst_n_i     = 1'b0;
        ex_valid_i  = 1'b1;
        mem_we_i    = 1'b0;
        mem_op_i    = 3'b010;
        alu_C_i     = 32'h100;
        rf_rd2_i    = 32'h0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;
        last_wb     = 32'h0;
        #1;
        check("rst_stall", stall_o, 1'b0);
        check("rst_req", bus_req_o, 1'b0);
        check("rst_wbv", wb_valid_o, 1'b0);
        check("rst_wbdata", wb_data_o, 32'h0);
        check("rst_addr", bus_addr_o, 32'h0);
        check("rst_be", bus_be_o, 4'h0);
        check("rst_flags", {misalign_o, bus_err_o, bus_we_o}, 3'b000);
        ex_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        // Directed cases with values fixed in advance.
        access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, got, nb);
        check("lw_const", got, 32'hDEADBEEF);
        access(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80FFFF7F, got, nb);
        check("lb_const", got, 32'hFFFFFF80);
        access(1'b0, 3'b100, 32'h103, 32'h0, 2, 32'h80FFFF7F, got, nb);
        check("lbu_const", got, 32'h00000080);
        access(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 32'h0, got, nb);
        access(1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0, got, nb);
        access(1'b0, 3'b010, 32'h200, 32'h0, TO + 1, 32'h0, got, nb);
        check("timeout_len", nb, TO + 1);
        access(1'b0, 3'b101, 32'h206, 32'h0, TO, 32'h8001_1234, got, nb);
        check("ack_at_timeout", got, 32'h00008001);

        // Reset in the middle of a bus transaction.
        ex_valid_i = 1'b1; mem_we_i = 1'b0; mem_op_i = 3'b010; alu_C_i = 32'h300;
        @(posedge clk_i); #1;
        ex_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("midbus_req", bus_req_o, 1'b1);
        rst_n_i = 1'b0;
        #1;
        check("rstbus_req", bus_req_o, 1'b0);
        check("rstbus_stall", stall_o, 1'b0);
        check("rstbus_wbdata", wb_data_o, 32'h0);
        last_wb = 32'h0;
        bus_ack_i = 1'b1;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        bus_ack_i = 1'b0;
        @(posedge clk_i); #1;
        check("rstbus_nowb", wb_valid_o, 1'b0);
        check("rstbus_noerr", bus_err_o, 1'b0);
        access(1'b0, 3'b001, 32'h2, 32'h0, 1, 32'hF00D_0000, got, nb);
        check("after_rst", got, 32'hFFFFF00D);

        // Randomized traffic with stray acks between accesses.
        for (int t = 0; t < 150; t++) begin
            bus_ack_i  = 1'($urandom_range(0, 1));
            ex_valid_i = 1'b0;
            @(posedge clk_i); #1;
            bus_ack_i = 1'b0;
            check("idle_ack_req", bus_req_o, 1'b0);
            check("idle_ack_wb", wb_valid_o, 1'b0);
            check("idle_ack_err", bus_err_o, 1'b0);
            op   = 3'($urandom);
            addr = $urandom & 32'h0000_0FFF;
            lat  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, TO)) : TO + 1;
            access(1'($urandom), op, addr, $urandom, lat, $urandom, got, nb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
